// File: rtl/mems_uart_pkg.sv
// mems_uart_pkg: shared widths, FSM encoding and default gap for the MEMS UART scheduler
package mems_uart_pkg;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int GAP_CYCLES_DEF = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2,
    GAP     = 2'd3
  } state_t;
endpackage

// File: rtl/mems_rr_arbiter.sv
// mems_rr_arbiter: round-robin select with a registered rotating priority pointer
module mems_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic            sclk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] grant_next,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] j;
  // first set request at or above the pointer, wrapping; scanned downward so the nearest wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) idx = j;
    end
    grant_next = |req ? NREQ'(1) << idx : '0;
  end
  // pointer moves just past the winner whenever a grant is taken
  always_ff @(posedge sclk) begin
    if (!rst_n) ptr <= '0;
    else if (adv) ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/mems_uart_tx_sched.sv
// mems_uart_tx_sched: round-robin scheduler sending 16-bit words as two UART bytes with an idle gap
module mems_uart_tx_sched
  import mems_uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int GAP_W = 8
) (
  input  logic                    sclk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WORD_W-1:0]  req_data,
  output logic [NREQ-1:0]         grant,
  output logic [BYTE_W-1:0]       byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] cur_id,
  output logic [15:0]             words_sent
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state, state_n;
  logic adv;
  logic [NREQ-1:0] grant_next;
  logic [IDW-1:0] idx;
  logic [WORD_W-1:0] sel_word;
  logic [BYTE_W-1:0] lo_byte;
  logic [GAP_W-1:0] gap_cnt;
  assign adv = (state == IDLE) && |req;
  assign sel_word = req_data[WORD_W*int'(idx) +: WORD_W];
  mems_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .sclk(sclk),
    .rst_n(rst_n),
    .req(req),
    .adv(adv),
    .grant_next(grant_next),
    .idx(idx)
  );
  // next state: a byte leaves only on valid && ready, the gap ends when the counter hits zero
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? SEND_HI : IDLE;
      SEND_HI: state_n = byte_ready ? SEND_LO : SEND_HI;
      SEND_LO: state_n = !byte_ready ? SEND_LO : (GAP_CYCLES > 0 ? GAP : IDLE);
      GAP:     state_n = (gap_cnt == '0) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // registered outputs; the low byte is captured at grant so later req_data changes cannot leak in
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      busy <= 1'b0;
      cur_id <= '0;
      words_sent <= '0;
      lo_byte <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      grant <= adv ? grant_next : '0;
      if (adv) begin
        lo_byte <= sel_word[BYTE_W-1:0];
        byte_data <= sel_word[WORD_W-1:BYTE_W];
        byte_valid <= 1'b1;
        cur_id <= idx;
      end
      if (state == SEND_HI && byte_ready) byte_data <= lo_byte;
      if (state == SEND_LO && byte_ready) begin
        byte_valid <= 1'b0;
        words_sent <= words_sent + 1'b1;
        gap_cnt <= GAP_LOAD;
      end
      if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end
endmodule
